// File: rtl/ref_clock_out_pkg.sv
// Shared clock-domain constants: reference-output FSM encoding and the
// 250 MHz timebase figures also used by the reference-input detector.
package ref_clock_out_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_DIV_10MHZ = 25;
    localparam int unsigned SYS_CLK_HZ        = 250_000_000;
    localparam int unsigned MIN_PERIOD        = 2;

endpackage

// File: rtl/ref_clock_out.sv
// 10 MHz reference square-wave generator for the REF out connector.
// Glitch-free enable/disable, period-boundary divisor latch, sync realign.
module ref_clock_out
    import ref_clock_out_pkg::*;
#(
    parameter int unsigned DIV_WIDTH   = 8,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_10MHZ
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic                 sync_in,
    output logic                 ref_out,
    output logic                 active,
    output logic                 period_start
);

    localparam int unsigned EXT_WIDTH = DIV_WIDTH + 1;

    state_t               r_state;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [DIV_WIDTH-1:0] r_div;
    logic                 r_ref_out;
    logic                 r_active;
    logic                 r_period_start;

    state_t               w_state_nxt;
    logic [DIV_WIDTH-1:0] w_cnt_nxt;
    logic [DIV_WIDTH-1:0] w_div_nxt;
    logic                 w_ref_nxt;
    logic                 w_ps_nxt;
    logic                 w_counting;

    logic [DIV_WIDTH-1:0] w_period;
    logic [EXT_WIDTH-1:0] w_period_ext;
    logic [DIV_WIDTH-1:0] w_high;
    logic                 w_last;
    logic [DIV_WIDTH-1:0] w_cnt_inc;

    // Effective period clamped to 2; high length rounded up, computed one bit wider
    assign w_period     = (r_div < DIV_WIDTH'(MIN_PERIOD)) ? DIV_WIDTH'(MIN_PERIOD) : r_div;
    assign w_period_ext = EXT_WIDTH'(w_period) + EXT_WIDTH'(1);
    assign w_high       = DIV_WIDTH'(w_period_ext >> 1);
    assign w_last       = (r_cnt == (w_period - DIV_WIDTH'(1)));
    assign w_cnt_inc    = r_cnt + DIV_WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_div          <= DIV_WIDTH'(DEFAULT_DIV);
            r_ref_out      <= 1'b0;
            r_active       <= 1'b0;
            r_period_start <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_div          <= w_div_nxt;
            r_ref_out      <= w_ref_nxt;
            r_active       <= (w_state_nxt != ST_IDLE);
            r_period_start <= w_ps_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_div_nxt   = r_div;
        w_ref_nxt   = r_ref_out;
        w_ps_nxt    = 1'b0;
        w_counting  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_ref_nxt = 1'b0;
                if (enable) begin
                    w_cnt_nxt   = '0;
                    w_div_nxt   = div;
                    w_ref_nxt   = 1'b1;
                    w_ps_nxt    = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_counting = 1'b1;
                w_cnt_nxt  = (w_last || sync_in) ? '0 : w_cnt_inc;
                if (!enable) begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                // Disable only takes effect once the running period completes
                if (w_last && !enable) begin
                    w_cnt_nxt   = '0;
                    w_ref_nxt   = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_counting = 1'b1;
                    w_cnt_nxt  = w_last ? '0 : w_cnt_inc;
                    if (enable) begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            default: begin
                w_ref_nxt   = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase

        // New period: latch divisor and flag the rising edge
        if (w_counting) begin
            w_ref_nxt = (w_cnt_nxt < w_high);
            if (w_cnt_nxt == '0) begin
                w_div_nxt = div;
                w_ps_nxt  = 1'b1;
            end
        end
    end

    assign ref_out      = r_ref_out;
    assign active       = r_active;
    assign period_start = r_period_start;

endmodule

// File: tb/tb_ref_clock_out.sv
// Directed bench for ref_clock_out: expected {ref_out, active, period_start}
// per cycle is queued ahead of stimulus and compared as the DUT advances.
module tb_ref_clock_out;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b1;
    logic       enable  = 1'b0;
    logic       sync_in = 1'b0;
    logic [7:0] div     = 8'd25;
    logic       ref_out;
    logic       active;
    logic       period_start;

    logic [2:0] exp_q[$];
    int         n_chk   = 0;
    int         n_pass  = 0;
    int         n_fail  = 0;
    int         n_edges = 0;
    logic       prev_ref = 1'b0;

    ref_clock_out #(
        .DIV_WIDTH   (8),
        .DEFAULT_DIV (25)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .div          (div),
        .sync_in      (sync_in),
        .ref_out      (ref_out),
        .active       (active),
        .period_start (period_start)
    );

    initial forever #2 clk = ~clk;

    task automatic push(input logic r, input logic a, input logic p, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({r, a, p});
    endtask

    task automatic push_period(input int n, input int h);
        push(1'b1, 1'b1, 1'b1, 1);
        push(1'b1, 1'b1, 1'b0, h - 1);
        push(1'b0, 1'b1, 1'b0, n - h);
    endtask

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed {ref,act,ps}=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int lo, input int hi);
        n_chk++;
        assert (obs >= lo && obs <= hi) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic run(input string tag, input int n);
        logic [2:0] obs;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            obs = {ref_out, active, period_start};
            if (ref_out !== prev_ref) n_edges++;
            prev_ref = ref_out;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $error("FAIL %s observed=%b expected=<queue empty>", tag, obs);
            end else begin
                check(tag, obs, exp_q.pop_front());
            end
        end
    endtask

    initial begin
        // Asynchronous reset, checked before any clock edge
        rst_n = 1'b0;
        #1;
        check("reset_async", {ref_out, active, period_start}, 3'b000);
        repeat (3) @(posedge clk);
        #1;
        check("reset_held", {ref_out, active, period_start}, 3'b000);
        rst_n = 1'b1;
        push(1'b0, 1'b0, 1'b0, 2);
        run("idle", 2);

        // Enable at 25: 13 high / 12 low
        enable = 1'b1;
        push_period(25, 13);
        push_period(25, 13);
        run("run25", 50);

        // 256-cycle window edge count
        n_edges = 0;
        for (int k = 0; k < 10; k++) push_period(25, 13);
        push(1'b1, 1'b1, 1'b1, 1);
        push(1'b1, 1'b1, 1'b0, 5);
        run("window", 256);
        check_int("edges_256", n_edges, 20, 21);

        // Disable at cnt=5: period completes, then idle
        enable = 1'b0;
        push(1'b1, 1'b1, 1'b0, 7);
        push(1'b0, 1'b1, 1'b0, 12);
        push(1'b0, 1'b0, 1'b0, 4);
        run("stop", 23);

        // Divisor change 25->10 at cnt=3
        div    = 8'd25;
        enable = 1'b1;
        push(1'b1, 1'b1, 1'b1, 1);
        push(1'b1, 1'b1, 1'b0, 3);
        run("div_pre", 4);
        div = 8'd10;
        push(1'b1, 1'b1, 1'b0, 9);
        push(1'b0, 1'b1, 1'b0, 12);
        push_period(10, 5);
        push_period(10, 5);
        run("div_chg", 41);

        // Back to 25, sync in low phase at cnt=15
        div = 8'd25;
        push(1'b1, 1'b1, 1'b1, 1);
        push(1'b1, 1'b1, 1'b0, 12);
        push(1'b0, 1'b1, 1'b0, 3);
        run("pre_sync", 16);
        sync_in = 1'b1;
        push(1'b1, 1'b1, 1'b1, 1);
        run("sync_low", 1);
        sync_in = 1'b0;
        push(1'b1, 1'b1, 1'b0, 12);
        push(1'b0, 1'b1, 1'b0, 12);
        run("post_sync", 24);

        // Sync coincident with cnt=24: single restart
        sync_in = 1'b1;
        push_period(25, 13);
        run("sync_last", 1);
        sync_in = 1'b0;
        run("sync_last", 24);
        push_period(25, 13);
        run("after_sync", 25);

        // Disable at cnt=0, then sync while idle
        push(1'b1, 1'b1, 1'b1, 1);
        run("stop0_pre", 1);
        enable = 1'b0;
        push(1'b1, 1'b1, 1'b0, 12);
        push(1'b0, 1'b1, 1'b0, 12);
        push(1'b0, 1'b0, 1'b0, 1);
        run("stop0", 25);
        sync_in = 1'b1;
        push(1'b0, 1'b0, 1'b0, 3);
        run("sync_idle", 3);
        sync_in = 1'b0;

        // Reset mid-high phase
        enable = 1'b1;
        push(1'b1, 1'b1, 1'b1, 1);
        push(1'b1, 1'b1, 1'b0, 4);
        run("pre_reset", 5);
        rst_n = 1'b0;
        #0.5;
        check("reset_mid", {ref_out, active, period_start}, 3'b000);
        enable = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        prev_ref = ref_out;
        push(1'b0, 1'b0, 1'b0, 2);
        run("post_reset", 2);

        // div=1 clamps to N=2
        div    = 8'd1;
        enable = 1'b1;
        for (int k = 0; k < 4; k++) push_period(2, 1);
        run("div1", 8);

        check_int("queue_drained", exp_q.size(), 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
